// File: rtl/rrn_pkg.sv
// Shared definitions for the round-robin AXI-Stream arbiter:
// FSM state encoding, source-index width helper and the channel-count limit.
package rrn_pkg;

  localparam int RRN_MAX_INPUTS = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } rrn_state_e;

  // Width of a source index; a single input still needs one bit.
  function automatic int rrn_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_slice2.sv
// Two-entry register slice for the arbiter output. Holds the beat payload
// in head/tail registers; only the occupancy counter is reset, so a reset
// simply discards whatever the storage still contains.
module axis_slice2 #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             rdy,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             full
);

  logic [1:0]       count;
  logic [WIDTH-1:0] head_p1;
  logic [WIDTH-1:0] tail_p1;
  logic             pop;
  logic             push_ok;

  assign vld     = (count != 2'd0);
  assign full    = (count == 2'd2);
  assign pop     = vld & rdy;
  assign push_ok = push & (~full | pop);
  assign dout    = head_p1;

  // Occupancy: push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
    end else if (push_ok & ~pop) begin
      count <= count + 2'd1;
    end else if (pop & ~push_ok) begin
      count <= count - 2'd1;
    end
  end

  // Stage 1 storage: head is always the oldest beat; tail only fills when head is busy.
  always_ff @(posedge clk) begin
    if (push_ok & pop) begin
      if (count == 2'd2) begin
        head_p1 <= tail_p1;
        tail_p1 <= din;
      end else begin
        head_p1 <= din;
      end
    end else if (push_ok) begin
      if (count == 2'd0) begin
        head_p1 <= din;
      end else begin
        tail_p1 <= din;
      end
    end else if (pop) begin
      head_p1 <= tail_p1;
    end
  end

endmodule

// File: rtl/rrn_axis_arb.sv
// N-to-1 round-robin AXI-Stream arbiter with registered grant and a
// 2-entry output register slice. s_TREADY depends only on registers, so
// there is no combinational path from any s_TVALID to any s_TREADY.
// Optional feature macro: RRN_TDEST_EN adds o_TDEST (source index carried
// through the slice alongside its beat).
module rrn_axis_arb
  import rrn_pkg::*;
#(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TLAST_ARB  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] s_TDATA,
  input  logic [N_INPUTS-1:0]            s_TVALID,
  output logic [N_INPUTS-1:0]            s_TREADY,
  input  logic [N_INPUTS-1:0]            s_TLAST,
  output logic [DATA_WIDTH-1:0]          o_TDATA,
  output logic                           o_TVALID,
  input  logic                           o_TREADY,
  output logic                           o_TLAST
`ifdef RRN_TDEST_EN
  ,
  output logic [rrn_idx_w(N_INPUTS)-1:0] o_TDEST
`endif
);

  localparam int IDX_W = rrn_idx_w(N_INPUTS);
`ifdef RRN_TDEST_EN
  localparam int SLICE_W = DATA_WIDTH + 1 + IDX_W;
`else
  localparam int SLICE_W = DATA_WIDTH + 1;
`endif

  if (N_INPUTS < 1 || N_INPUTS > RRN_MAX_INPUTS) begin : g_n_range
    $error("rrn_axis_arb: N_INPUTS out of range");
  end

  rrn_state_e            state, state_nx;
  logic [N_INPUTS-1:0]   owner, owner_nx;
  logic [IDX_W-1:0]      ptr, ptr_nx;
  logic [IDX_W-1:0]      owner_idx;
  logic                  first_grant, first_nx;
  logic                  slice_full;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  accept;
  logic                  term;
  logic [SLICE_W-1:0]    slice_in;
  logic [SLICE_W-1:0]    slice_out;

  // First requester at or after index 'start', wrapping: the request vector is
  // doubled, everything below 'start' is masked off, and the lowest surviving
  // bit is isolated and folded back onto N bits.
  function automatic logic [N_INPUTS-1:0] rr_pick(input logic [N_INPUTS-1:0] req,
                                                  input int                  start);
    logic [2*N_INPUTS-1:0] dreq;
    logic [2*N_INPUTS-1:0] masked;
    logic [2*N_INPUTS-1:0] lowest;
    dreq   = {req, req};
    masked = dreq & ({(2*N_INPUTS){1'b1}} << start);
    lowest = masked & (-masked);
    return lowest[N_INPUTS-1:0] | lowest[2*N_INPUTS-1:N_INPUTS];
  endfunction

  // One-hot owner to index.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (owner[i]) owner_idx = IDX_W'(i);
    end
  end

  // Input mux: AND-OR select of the owner's beat.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (owner[i]) sel_data = sel_data | s_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_valid = |(s_TVALID & owner);
  assign sel_last  = |(s_TLAST & owner);
  assign s_TREADY  = (state == ST_LOCK) ? (owner & {N_INPUTS{~slice_full}}) : '0;
  assign accept    = (state == ST_LOCK) & sel_valid & ~slice_full;
  assign term      = accept & ((TLAST_ARB == 0) | sel_last);

  // Next grant. After reset input 0 has top priority; from then on the search
  // starts just after the last owner. The finishing owner's own valid counts
  // as a request, at lowest priority, so it keeps the grant when alone.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    ptr_nx   = ptr;
    first_nx = first_grant;
    case (state)
      ST_IDLE: begin
        if (|s_TVALID) begin
          owner_nx = rr_pick(s_TVALID, first_grant ? int'(ptr) : int'(ptr) + 1);
          first_nx = 1'b0;
          state_nx = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (term) begin
          ptr_nx = owner_idx;
          if (|s_TVALID) begin
            owner_nx = rr_pick(s_TVALID, int'(owner_idx) + 1);
          end else begin
            owner_nx = '0;
            state_nx = ST_IDLE;
          end
        end
      end
      default: begin
        owner_nx = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Grant state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      ptr         <= '0;
      first_grant <= 1'b1;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      ptr         <= ptr_nx;
      first_grant <= first_nx;
    end
  end

`ifdef RRN_TDEST_EN
  assign slice_in = {owner_idx, sel_last, sel_data};
  assign o_TDEST  = slice_out[DATA_WIDTH+1 +: IDX_W];
`else
  assign slice_in = {sel_last, sel_data};
`endif

  // Stage boundary: accepted beat enters the output register slice.
  axis_slice2 #(
    .WIDTH(SLICE_W)
  ) u_slice (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .din  (slice_in),
    .rdy  (o_TREADY),
    .dout (slice_out),
    .vld  (o_TVALID),
    .full (slice_full)
  );

  assign o_TDATA = slice_out[DATA_WIDTH-1:0];
  assign o_TLAST = slice_out[DATA_WIDTH];

endmodule
